// File: rtl/etc_pkg.sv
// Shared definitions for the semiring tile MMA: op encodings, FSM states,
// identity selection and a width-generic saturating add.
package etc_pkg;

  typedef enum logic [3:0] {
    OP_PLUS_TIMES = 4'd0,
    OP_MIN_PLUS   = 4'd1,
    OP_MAX_PLUS   = 4'd2,
    OP_MAX_MIN    = 4'd3,
    OP_MIN_MAX    = 4'd4,
    OP_OR_AND     = 4'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  // Widest element the saturating add can serve; lanes pass their own W.
  localparam int unsigned MAX_W = 64;

  function automatic logic op_supported(input logic [3:0] op);
    return op <= OP_OR_AND;
  endfunction

  // Min-based semirings start from "infinity" (all ones), the rest from zero.
  function automatic logic identity_ones(input logic [3:0] op);
    return (op == OP_MIN_PLUS) || (op == OP_MIN_MAX);
  endfunction

  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int unsigned      w);
    logic [MAX_W:0] sum;
    logic [MAX_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
    return (sum > lim) ? lim[MAX_W-1:0] : sum[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/etc_semiring_mma_if.sv
// Operand/result handshake bundle between the tile register file (master)
// and the semiring MMA unit (slave).
interface etc_semiring_mma_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
);
  logic [3:0]                    op;
  logic                          in_acc;
  logic                          in_valid;
  logic                          in_ready;
  logic [N-1:0][N-1:0][W-1:0]    in_a;
  logic [N-1:0][N-1:0][W-1:0]    in_b;
  logic [N-1:0][N-1:0][W-1:0]    in_c;
  logic                          out_valid;
  logic                          out_ready;
  logic [N-1:0][N-1:0][W-1:0]    out_d;
  logic                          out_err;

  modport master (
    output op, in_acc, in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_d, out_err
  );

  modport slave (
    input  op, in_acc, in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_d, out_err
  );
endinterface

// File: rtl/etc_semiring_pe.sv
// One W-bit lane: acc_next = acc (+) (a (x) b) under the selected semiring.
// Unsupported ops collapse the lane to zero.
module etc_semiring_pe
  import etc_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] acc_next
);

  logic [MAX_W-1:0] sum_ext;
  logic [W-1:0]     sum_sat;
  logic [W-1:0]     prod;
  logic [W-1:0]     mn;
  logic [W-1:0]     mx;

  assign sum_ext = sat_add(MAX_W'(a), MAX_W'(b), W);
  assign sum_sat = sum_ext[W-1:0];
  assign prod    = a * b;
  assign mn      = (a < b) ? a : b;
  assign mx      = (a > b) ? a : b;

  // Upper bits of the clamped sum are always zero for a W-bit lane.
  if (W < MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = |sum_ext[MAX_W-1:W];
  end

  always_comb begin
    case (op)
      OP_PLUS_TIMES: acc_next = acc + prod;
      OP_MIN_PLUS:   acc_next = (sum_sat < acc) ? sum_sat : acc;
      OP_MAX_PLUS:   acc_next = (sum_sat > acc) ? sum_sat : acc;
      OP_MAX_MIN:    acc_next = (mn > acc) ? mn : acc;
      OP_MIN_MAX:    acc_next = (mx < acc) ? mx : acc;
      OP_OR_AND:     acc_next = acc | (a & b);
      default:       acc_next = '0;
    endcase
  end

endmodule

// File: rtl/etc_semiring_mma.sv
// N x N semiring tile MMA: D = C (+) (A (x) B), one rank-1 update per cycle
// over N cycles, with a valid/ready result held until the consumer takes it.
module etc_semiring_mma
  import etc_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  etc_semiring_mma_if.slave bus
);

  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef logic [N-1:0][N-1:0][W-1:0] tile_t;

  state_e        state;
  state_e        state_next;
  logic [KW-1:0] k;
  logic [3:0]    op_q;
  logic          err_q;
  tile_t         a_q;
  tile_t         b_q;
  tile_t         acc;
  tile_t         acc_next;
  logic          accept;
  logic          last_step;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_step = (k == KW'(N - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next defaults to the current state before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)        state_next = ST_BUSY;
      ST_BUSY: if (last_step)     state_next = ST_DONE;
      ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == ST_IDLE) && rst_n;
    bus.out_valid = (state == ST_DONE);
  end

  // Accumulators double as the result register; they only move on accept
  // and in BUSY, so out_d is stable throughout DONE.
  assign bus.out_d   = acc;
  assign bus.out_err = err_q;

  // NOTE: the accumulator array is reset because its zero value is
  // architecturally visible on out_d; the operand latches reset alongside
  // for the same reason of deterministic state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      err_q <= 1'b0;
      k     <= '0;
    end else if (accept) begin
      a_q   <= bus.in_a;
      b_q   <= bus.in_b;
      op_q  <= bus.op;
      err_q <= !op_supported(bus.op);
      k     <= '0;
      if (bus.in_acc)                acc <= bus.in_c;
      else if (identity_ones(bus.op)) acc <= '1;
      else                           acc <= '0;
    end else if (state == ST_BUSY) begin
      acc <= acc_next;
      k   <= k + KW'(1);
    end
  end

  // Lane (i,j) consumes column k of A and row k of B this cycle.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      etc_semiring_pe #(.W(W)) u_pe (
        .op       (op_q),
        .acc      (acc[i][j]),
        .a        (a_q[i][k]),
        .b        (b_q[k][j]),
        .acc_next (acc_next[i][j])
      );
    end
  end

endmodule

// File: tb/tb_etc_semiring_mma.sv
// Directed scoreboard bench for etc_semiring_mma: a 4x4x16 instance for the
// main scenarios and an 8x8x8 instance for the generalised max-min case.
module tb_etc_semiring_mma;
  import etc_pkg::*;

  localparam int N0 = 4;
  localparam int W0 = 16;
  localparam int N1 = 8;
  localparam int W1 = 8;

  typedef logic [511:0] vec_t;
  typedef logic [N0-1:0][N0-1:0][W0-1:0] tile0_t;
  typedef struct packed {
    logic err;
    vec_t d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  etc_semiring_mma_if #(.N(N0), .W(W0)) if0 ();
  etc_semiring_mma_if #(.N(N1), .W(W1)) if1 ();

  etc_semiring_mma #(.N(N0), .W(W0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  etc_semiring_mma #(.N(N1), .W(W1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic vec_t rnd();
    vec_t r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] get(input vec_t v, input int i, input int j,
                                      input int n, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return 64'(v >> ((i*n + j)*w)) & m;
  endfunction

  // Independent element-by-element reference of the semiring product.
  function automatic vec_t model(input int op, input logic acc_in, input vec_t a,
                                 input vec_t b, input vec_t c, input int n, input int w);
    vec_t d;
    logic [63:0] m, ac, x, y, s;
    m = (64'd1 << w) - 64'd1;
    d = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        if (acc_in)                 ac = get(c, i, j, n, w);
        else if (op == 1 || op == 4) ac = m;
        else                        ac = 64'd0;
        for (int kk = 0; kk < n; kk++) begin
          x = get(a, i, kk, n, w);
          y = get(b, kk, j, n, w);
          s = x + y;
          if (s > m) s = m;
          case (op)
            0: ac = (ac + x*y) & m;
            1: if (s < ac) ac = s;
            2: if (s > ac) ac = s;
            3: if (((x < y) ? x : y) > ac) ac = (x < y) ? x : y;
            4: if (((x > y) ? x : y) < ac) ac = (x > y) ? x : y;
            5: ac = ac | (x & y);
            default: ac = 64'd0;
          endcase
        end
        d = d | (vec_t'(ac) << ((i*n + j)*w));
      end
    end
    return d;
  endfunction

  task automatic run_op(input int sel, input logic [3:0] op, input logic acc_in,
                        input vec_t a, input vec_t b, input vec_t c,
                        input logic push, input exp_t e);
    int budget;
    budget = 0;
    @(negedge clk);
    if (sel == 0) begin
      if0.op = op; if0.in_acc = acc_in; if0.in_valid = 1'b1;
      if0.in_a = a[255:0]; if0.in_b = b[255:0]; if0.in_c = c[255:0];
    end else begin
      if1.op = op; if1.in_acc = acc_in; if1.in_valid = 1'b1;
      if1.in_a = a; if1.in_b = b; if1.in_c = c;
    end
    while (!((sel == 0) ? if0.in_ready : if1.in_ready) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("accept_wait", vec_t'(budget < 50), 1);
    @(posedge clk);
    if (push) begin
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
  endtask

  task automatic wait_result(input int sel, input string tag, input int hold);
    int   lat;
    logic v;
    vec_t r, d_obs;
    exp_t e;
    lat = 0;
    forever begin
      @(negedge clk);
      if (lat == 0) begin
        r = rnd();
        if (sel == 0) begin
          if0.in_valid = 1'b0; if0.in_a = r[255:0]; if0.in_b = r[511:256];
          if0.in_c = r[255:0]; if0.op = r[3:0]; if0.in_acc = r[4];
        end else begin
          if1.in_valid = 1'b0; if1.in_a = r; if1.in_b = ~r; if1.in_c = r;
          if1.op = r[3:0]; if1.in_acc = r[4];
        end
      end
      v = (sel == 0) ? if0.out_valid : if1.out_valid;
      if (v || lat >= 100) break;
      lat++;
    end
    check({tag, "_latency"}, vec_t'(lat), vec_t'((sel == 0) ? N0 : N1));
    check({tag, "_queued"}, vec_t'((sel == 0) ? q0.size() : q1.size()), 1);
    if (sel == 0 && q0.size() > 0)      e = q0.pop_front();
    else if (sel == 1 && q1.size() > 0) e = q1.pop_front();
    else                                e = '0;
    d_obs = (sel == 0) ? vec_t'(if0.out_d) : vec_t'(if1.out_d);
    check({tag, "_d"}, d_obs, e.d);
    check({tag, "_err"}, vec_t'((sel == 0) ? if0.out_err : if1.out_err), vec_t'(e.err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      r = rnd();
      if0.in_valid = ~if0.in_valid;
      if0.in_a = r[255:0];
      #1;
      check({tag, "_hold_d"}, vec_t'(if0.out_d), e.d);
      check({tag, "_hold_ready"}, vec_t'(if0.in_ready), 0);
      check({tag, "_hold_valid"}, vec_t'(if0.out_valid), 1);
    end
    if (sel == 0) begin if0.in_valid = 1'b0; if0.out_ready = 1'b1; end
    else          begin if1.in_valid = 1'b0; if1.out_ready = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b0;
    check({tag, "_consumed"}, vec_t'((sel == 0) ? if0.out_valid : if1.out_valid), 0);
    check({tag, "_ready_again"}, vec_t'((sel == 0) ? if0.in_ready : if1.in_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tile0_t ta, tbm, tc, te;
    vec_t   ra, rb, rc;
    exp_t   ex;
    int     seen;

    rst_n = 1'b0;
    if0.op = '0; if0.in_acc = 0; if0.in_valid = 0; if0.out_ready = 0;
    if0.in_a = '0; if0.in_b = '0; if0.in_c = '0;
    if1.op = '0; if1.in_acc = 0; if1.in_valid = 0; if1.out_ready = 0;
    if1.in_a = '0; if1.in_b = '0; if1.in_c = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready", vec_t'(if0.in_ready), 0);
    check("rst_out_valid", vec_t'(if0.out_valid), 0);
    check("rst_out_d", vec_t'(if0.out_d), 0);
    check("rst_out_err", vec_t'(if0.out_err), 0);
    check("rst_in_ready_n8", vec_t'(if1.in_ready), 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", vec_t'(if0.in_ready), 1);

    // Plus-times from the identity.
    ta = '0; tbm = '0; te = '0;
    ta[0][0] = 1; ta[0][1] = 1; ta[0][2] = 5; ta[0][3] = 2; ta[1][0] = 3; ta[2][0] = 1;
    tbm[0][0] = 1; tbm[1][0] = 1; tbm[2][0] = 6; tbm[3][0] = 2; tbm[0][1] = 3; tbm[0][2] = 8;
    te[0][0] = 36; te[0][1] = 3; te[0][2] = 8;
    te[1][0] = 3;  te[1][1] = 9; te[1][2] = 24;
    te[2][0] = 1;  te[2][1] = 3; te[2][2] = 8;
    ex.err = 1'b0; ex.d = vec_t'(te);
    run_op(0, OP_PLUS_TIMES, 1'b0, vec_t'(ta), vec_t'(tbm), '0, 1'b1, ex);
    wait_result(0, "plus_times", 0);

    // Min-plus with saturation to infinity.
    ta = '1; tbm = '1; te = '1;
    ta[0][0] = 16'hFFF0; tbm[0][0] = 16'h0020; ta[1][1] = 2; tbm[1][1] = 3;
    te[1][1] = 5;
    ex.err = 1'b0; ex.d = vec_t'(te);
    run_op(0, OP_MIN_PLUS, 1'b0, vec_t'(ta), vec_t'(tbm), '0, 1'b1, ex);
    wait_result(0, "min_plus_sat", 0);

    // Accumulate onto C, with out_ready already high during BUSY.
    ta = '0;
    for (int i = 0; i < N0; i++) begin
      ta[i][i] = 1;
      for (int j = 0; j < N0; j++) begin
        tc[i][j] = 7; tbm[i][j] = 2; te[i][j] = 9;
      end
    end
    ex.err = 1'b0; ex.d = vec_t'(te);
    if0.out_ready = 1'b1;
    run_op(0, OP_PLUS_TIMES, 1'b1, vec_t'(ta), vec_t'(tbm), vec_t'(tc), 1'b1, ex);
    wait_result(0, "accumulate", 0);

    // Back-pressure on an or-and result.
    ra = rnd(); rb = rnd(); rc = rnd();
    ex.err = 1'b0; ex.d = model(5, 1'b1, ra, rb, rc, N0, W0);
    run_op(0, OP_OR_AND, 1'b1, ra, rb, rc, 1'b1, ex);
    wait_result(0, "backpressure", 5);

    // Max-plus random coverage.
    ra = rnd(); rb = rnd();
    ex.err = 1'b0; ex.d = model(2, 1'b0, ra, rb, '0, N0, W0);
    run_op(0, OP_MAX_PLUS, 1'b0, ra, rb, '0, 1'b1, ex);
    wait_result(0, "max_plus", 0);

    // Unsupported op.
    ra = rnd(); rb = rnd(); rc = rnd();
    ex.err = 1'b1; ex.d = '0;
    run_op(0, 4'd9, 1'b1, ra, rb, rc, 1'b1, ex);
    wait_result(0, "bad_op", 0);

    // Reset while BUSY at k = 2: nothing may be emitted.
    ex = '0;
    run_op(0, OP_PLUS_TIMES, 1'b0, rnd(), rnd(), '0, 1'b0, ex);
    @(negedge clk);
    if0.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", vec_t'(if0.in_ready), 0);
    check("midrst_out_valid", vec_t'(if0.out_valid), 0);
    check("midrst_out_d", vec_t'(if0.out_d), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_ready_after", vec_t'(if0.in_ready), 1);
    seen = 0;
    for (int c = 0; c < N0 + 2; c++) begin
      @(negedge clk);
      if (if0.out_valid) seen++;
    end
    check("midrst_no_result", vec_t'(seen), 0);

    ra = rnd(); rb = rnd();
    ex.err = 1'b0; ex.d = model(0, 1'b0, ra, rb, '0, N0, W0);
    run_op(0, OP_PLUS_TIMES, 1'b0, ra, rb, '0, 1'b1, ex);
    wait_result(0, "after_reset", 0);

    // Generalised 8x8x8 max-min.
    for (int t = 0; t < 2; t++) begin
      ra = rnd(); rb = rnd(); rc = rnd();
      ex.err = 1'b0; ex.d = model(3, t[0], ra, rb, rc, N1, W1);
      run_op(1, OP_MAX_MIN, t[0], ra, rb, rc, 1'b1, ex);
      wait_result(1, "n8_max_min", 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/etc_semiring_mma.md
# etc_semiring_mma

Parametrised, handshaked successor to the 4x4 extended-tensor-core execute unit. It computes D = C ⊕ (A ⊗ B) over an N×N tile under a selectable semiring, one rank-1 update per cycle for N cycles. It sits between the tile register file, which drives the operands, and the writeback stage, which consumes results under back-pressure.

## Interface
- N, default 4: tile dimension; N ≥ 2.
- W, default 16: element width in bits, unsigned.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  4  semiring select; sampled at the accept edge.
- in_acc  in  1  1 = start from in_c; 0 = start from the ⊕-identity.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE and while rst_n is high.
- in_a, in_b, in_c  in  [N][N][W] packed, indexed [row][col]  operands; sampled at the accept edge.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_d  out  [N][N][W]  result; stable while out_valid is high.
- out_err  out  1  unsupported op; valid alongside out_valid.

## Operation
- Semirings (⊕ / ⊗ / ⊕-identity):
  - 0: plus / times / 0. Products and sums wrap modulo 2^W; keep the low W bits.
  - 1: min / plus / all-ones. Addition saturates to all-ones (infinity).
  - 2: max / plus / 0. Addition saturates to all-ones.
  - 3: max / min / 0.
  - 4: min / max / all-ones.
  - 5: bitwise or / bitwise and / 0.
  - 6..15: the result is all zeros and out_err = 1.
- Accept: on a rising edge with in_valid && in_ready.
  - Latch in_a, in_b and op.
  - Initialise the accumulator: if in_acc, acc[i][j] = in_c[i][j]; otherwise acc = ⊕-identity of op.
  - Clear the step counter k.
- FSM states are IDLE, BUSY and DONE.
  - IDLE → BUSY on accept.
  - In BUSY, each edge performs acc[i][j] ← acc[i][j] ⊕ (a[i][k] ⊗ b[k][j]) for all i, j, then k ← k+1.
  - BUSY → DONE on the edge that processes k = N−1. The counter is ceil(log2 N) bits and must not wrap early.
  - DONE holds out_valid = 1. DONE → IDLE on a rising edge with out_ready = 1.
- Inputs that change after the accept edge have no effect on the operation in flight.
- in_valid in BUSY or DONE is ignored; in_ready stays low.
- out_ready outside DONE is ignored.
- Reset values: state = IDLE, acc = 0, k = 0, out_valid = 0, out_err = 0, out_d = 0, in_ready = 0 while rst_n is low.
- Reset mid-operation: the operation is abandoned and no result is emitted. After rst_n rises, in_ready is 1 from the next evaluation.

## Timing
- Accept edge E0, then BUSY edges E1..EN. out_valid rises after EN, which is N cycles after acceptance.
- Zero-wait consumer: out_valid is high for exactly one cycle, and the next accept can occur at edge EN+2. Throughput is one tile per N+2 cycles.
- out_d and out_err are registered, with no combinational path from inputs to outputs. in_ready is decoded from state only.
- Timing path per update: one ⊗ plus one ⊕ per element, with N² lanes in parallel.

## Structure
- Package etc_pkg holds:
  - op encodings: OP_PLUS_TIMES … OP_OR_AND;
  - the identity-select function;
  - the FSM state enum;
  - the saturating-add function, parametrised by W.
- Sub-module etc_semiring_pe is one W-bit lane: combinational acc_next = acc ⊕ (a ⊗ b) under op. It is instantiated N² times by a generate loop.
- The top level holds the FSM, the counter, the operand latches and the accumulator registers.

## Test plan
All scenarios use N=4, W=16 unless stated.
- Plus-times, in_acc=0:
  - stimulus: A row0 = [1,1,5,2], A[1][0]=3, A[2][0]=1; B col0 = [1,1,6,2], B[0][1]=3, B[0][2]=8; all other elements 0;
  - required: D[0][0]=36, D[0][1]=3, D[0][2]=8, D[1][0]=3, D[1][1]=9, D[1][2]=24, D[2][0]=1, D[2][1]=3, D[2][2]=8, all others 0; out_valid exactly 4 cycles after accept.
- Min-plus saturation:
  - stimulus: A and B all 0xFFFF except A[0][0]=0xFFF0, B[0][0]=0x0020, A[1][1]=2, B[1][1]=3;
  - required: D[1][1]=5, every other element 0xFFFF.
- Accumulate:
  - stimulus: op 0, in_acc=1, C = all 7, A = identity, B = all 2;
  - required: every element of D = 9.
- Back-pressure:
  - stimulus: hold out_ready=0 for 5 cycles after out_valid rises; toggle in_valid and in_a meanwhile;
  - required: out_d stable, in_ready=0, and the result is consumed only on the out_ready edge.
- Error and reset:
  - stimulus: op=9;
  - required: out_err=1 and out_d all 0.
  - stimulus: drop rst_n at BUSY step k=2;
  - required: out_valid never rises and the next op completes correctly.
- Generalisation:
  - stimulus: N=8, W=8, op 3 (max-min) with random operands;
  - required: matches a bench reference model, with latency 8 cycles.
